// File: rtl/uart_rx_top.sv
// uart_rx_top: 8N1 UART receiver with 16x oversampling, MSB-first, holds last good byte
module uart_rx_top #(
  parameter int board_freq = 50000000,
  parameter int baud_rate  = 9600
) (
  input  logic       clk_board,
  input  logic       reset,
  input  logic       rx,
  input  logic       enable,
  output logic [7:0] data
);
  localparam int DIV = board_freq / (16 * baud_rate);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, tick;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [3:0] tcnt, tcnt_n;
  logic [2:0] bcnt, bcnt_n;
  logic [7:0] shift, shift_n, data_n;
  assign tick = enable && state != IDLE && dcnt == DW'(DIV - 1);
  always_ff @(posedge clk_board or negedge reset)
    if (!reset) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      state <= IDLE;
      dcnt  <= '0;
      tcnt  <= '0;
      bcnt  <= '0;
      shift <= '0;
      data  <= '0;
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      state <= state_n;
      dcnt  <= dcnt_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      shift <= shift_n;
      data  <= data_n;
    end
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    shift_n = shift;
    data_n  = data;
    dcnt_n  = (!enable || state == IDLE || tick) ? '0 : dcnt + 1'b1;
    if (!enable) begin
      state_n = IDLE;
      tcnt_n  = '0;
      bcnt_n  = '0;
    end else begin
      case (state)
        IDLE: if (!rx_s) begin
          state_n = START;
          tcnt_n  = '0;
          bcnt_n  = '0;
        end
        START: if (tick) begin
          tcnt_n = tcnt == 4'd7 ? 4'd0 : tcnt + 4'd1;
          if (tcnt == 4'd7) state_n = rx_s ? IDLE : DATA;
        end
        DATA: if (tick) begin
          tcnt_n = tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            shift_n = {shift[6:0], rx_s};
            bcnt_n  = bcnt + 3'd1;
            state_n = bcnt == 3'd7 ? STOP : DATA;
          end
        end
        STOP: if (tick) begin
          tcnt_n = tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            state_n = rx_s ? IDLE : WAIT_IDLE;
            data_n  = rx_s ? shift : data;
          end
        end
        WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed tests of uart_rx_top at 64 clocks per bit (DIV=4)
module tb_uart_rx_top;
  logic clk_board = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic enable = 1'b1;
  logic [7:0] data;
  int total = 0;
  int bad = 0;
  uart_rx_top #(.board_freq(64), .baud_rate(1)) dut (
    .clk_board(clk_board),
    .reset(reset),
    .rx(rx),
    .enable(enable),
    .data(data)
  );
  always #1 clk_board = ~clk_board;
  task automatic send_head(input logic [7:0] b);
    rx = 1'b0;
    #128;
    for (int i = 7; i >= 0; i--) begin
      rx = b[i];
      #128;
    end
  endtask
  task automatic send_frame(input logic [7:0] b);
    send_head(b);
    rx = 1'b1;
    #128;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    rx = 1'b1;
    enable = 1'b1;
    #256;
    total++;
    if (data !== 8'h00) begin bad++; $display("FAIL reset_value got=%h want=00", data); end
    reset = 1'b1;
    #512;
    total++;
    if (data !== 8'h00) begin bad++; $display("FAIL reset_idle got=%h want=00", data); end
  endtask
  task automatic test_frame(input logic [7:0] b, input logic [7:0] old);
    #512;
    send_head(b);
    total++;
    if (data !== old) begin bad++; $display("FAIL frame_early got=%h want=%h", data, old); end
    rx = 1'b1;
    #128;
    total++;
    if (data !== b) begin bad++; $display("FAIL frame_rx got=%h want=%h", data, b); end
    #256;
    total++;
    if (data !== b) begin bad++; $display("FAIL frame_stable got=%h want=%h", data, b); end
  endtask
  task automatic test_framing_error;
    #512;
    send_head(8'hAA);
    rx = 1'b0;
    #640;
    rx = 1'b1;
    #256;
    total++;
    if (data !== 8'h55) begin bad++; $display("FAIL framing_err got=%h want=55", data); end
    test_frame(8'h3C, 8'h55);
  endtask
  task automatic test_glitch;
    #512;
    rx = 1'b0;
    #40;
    rx = 1'b1;
    #512;
    total++;
    if (data !== 8'h3C) begin bad++; $display("FAIL glitch got=%h want=3c", data); end
    test_frame(8'hE7, 8'h3C);
  endtask
  task automatic test_enable_abort;
    #512;
    fork
      send_frame(8'hFF);
      begin
        #320;
        enable = 1'b0;
        #128;
        enable = 1'b1;
      end
    join
    #256;
    total++;
    if (data !== 8'hE7) begin bad++; $display("FAIL enable_abort got=%h want=e7", data); end
    test_frame(8'h96, 8'hE7);
  endtask
  task automatic test_reset_abort;
    #512;
    fork
      send_frame(8'h5A);
      begin
        #600;
        reset = 1'b0;
        #1;
        total++;
        if (data !== 8'h00) begin bad++; $display("FAIL reset_abort got=%h want=00", data); end
      end
    join
    #128;
    reset = 1'b1;
    #256;
    total++;
    if (data !== 8'h00) begin bad++; $display("FAIL reset_after got=%h want=00", data); end
    test_frame(8'hC3, 8'h00);
  endtask
  initial begin
    test_reset();
    test_frame(8'hAA, 8'h00);
    test_frame(8'h55, 8'hAA);
    test_framing_error();
    test_glitch();
    test_enable_abort();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
- Top-level UART receiver: 8 data bits, 1 start bit, 1 stop bit, no parity.
- Contains an internal baud/oversample tick generator, an input synchronizer, a receive FSM and an output data register.
- Sits at the board serial input and presents the last correctly framed byte on `data` for downstream display/processing logic.

Parameters:
- board_freq, default 50000000: system clock frequency in Hz. Must be an integer multiple of 16*baud_rate.
- baud_rate, default 9600: serial bit rate in bits/s. Oversampling is fixed at 16x, so DIV = board_freq/(16*baud_rate) ≥ 1.

Ports:
- clk_board  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx  input  1  asynchronous serial line; idles high.
- enable  input  1  receiver enable, active high.
- data  output  8  last correctly received byte.

Behaviour:
- Reset (reset=0, asynchronous):
  - data=8'h00.
  - FSM goes to IDLE; all counters clear.
  - Synchronizer flops set to 1 (idle level).
- rx synchronizer: 2-flop, so there is 2 cycles of latency before the FSM sees rx.
- Tick generator:
  - Counter 0..DIV-1 produces a one-cycle tick every DIV clocks.
  - Counts only while enable=1 and FSM≠IDLE.
  - Held at 0 in IDLE, so phase aligns to the start edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on synchronized rx=0 with enable=1, go to START and clear tick/sample counters.
  - START: count 8 ticks (mid start bit) and sample.
    - rx=0: go to DATA with bit index 0.
    - rx=1: false start; return to IDLE.
  - DATA: every 16 ticks, sample one bit at mid-bit.
    - Bit order is MSB first: first data bit goes to shift bit 7, eighth to bit 0.
    - After 8 bits, go to STOP.
  - STOP: after 16 ticks, sample at mid stop bit.
    - rx=1: data ← shift register on that cycle (visible the next clock); go to IDLE.
    - rx=0: framing error; data is NOT updated; go to WAIT_IDLE.
  - WAIT_IDLE: remain until synchronized rx=1, then go to IDLE. A held-low line (break) never produces a frame.
- enable=0:
  - FSM forced to IDLE and counters cleared on the next clock.
  - Any partial frame is discarded; data holds its value.
  - Re-enabling mid-frame may mis-frame. Required behaviour: no update unless a full valid frame including a high stop sample is seen.
- Latency: data updates 16·DIV·(1 + 8) + 8·DIV + ~3 clocks after the falling start edge, i.e. about mid stop bit.
- Back-to-back frames: a new start edge is accepted from IDLE immediately after the stop sample (half a stop bit early), so consecutive frames with 1 stop bit are received.
- Reset mid-frame: immediate abort; data=8'h00.
- No parity; no overrun detection. data simply holds until the next valid frame overwrites it.

Test Plan (board_freq=64, baud_rate=1, clk period 2 ns → 64 clocks = 128 ns per bit, DIV=4):
- Reset: hold reset=0 for 256 ns with rx=1, enable=1 → data=8'h00; no change after release while rx idles.
- Frame 1: after 512 ns idle, send start, bits 1,0,1,0,1,0,1,0, stop=1 (128 ns each) → data=8'hAA at ~mid stop bit; stable thereafter.
- Frame 2: after 512 ns idle, send start, bits 0,1,0,1,0,1,0,1, stop=1 → data=8'h55.
- Framing error: send start, bits 1,0,1,0,1,0,1,0, then rx=0 for 5 bit times, then rx=1 → data stays 8'h55. After rx returns high, a following valid frame 8'h3C is received correctly.
- Glitch/false start: rx low for 40 ns (20 clocks, < half bit) → no frame; data unchanged; FSM back in IDLE.
- Enable/reset abort: drop enable to 0 mid-frame for one bit time → data unchanged and the next valid frame is received. Separately, assert reset mid-frame → data=8'h00 immediately.
